// File: rtl/bch_chien_search.sv
// Serial Chien search over GF(2^M): evaluates sigma(alpha^k) for k = 0..N-1,
// flags roots as error positions, counts them and checks the count against deg(sigma).
module bch_chien_search #(
  parameter int M    = 4,
  parameter int T    = 3,
  parameter int POLY = 19
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [M*(T+1)-1:0] sigma_i,
  input  logic               accepted_i,
  output logic               busy_o,
  output logic               err_valid_o,
  output logic               err_o,
  output logic [M-1:0]       err_pos_o,
  output logic               done_o,
  output logic [M-1:0]       err_count_o,
  output logic               fail_o
);

  localparam int             N      = (1 << M) - 1;
  localparam logic [M-1:0]   K_LAST = M'(N - 1);
  localparam logic [M-1:0]   N_V    = M'(N);
  localparam logic [M:0]     POLY_V = (M+1)'(POLY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [T:0][M-1:0]     r_q, r_load, r_step;
  logic [M-1:0]          k_q, deg_q, deg_d, err_count_q, err_pos_q;
  logic [M-1:0]          eval, count_inc, pos_now;
  logic                  busy_q, err_valid_q, err_q, done_q, fail_q;
  logic                  load_en, step_en, release_en, last_step, eval_zero;

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
    logic [M:0] s;
    s = {v, 1'b0};
    if (s[M]) s = s ^ POLY_V;
    return s[M-1:0];
  endfunction

  // Coefficient j advances by alpha^j each step, so their XOR walks sigma(alpha^k).
  genvar gi;
  generate
    for (gi = 0; gi <= T; gi++) begin : g_coef
      logic [M-1:0] stepped;
      always_comb begin
        stepped = r_q[gi];
        for (int i = 0; i < gi; i++) stepped = mul_alpha(stepped);
      end
      assign r_step[gi] = stepped;
      assign r_load[gi] = sigma_i[gi*M +: M];
    end
  endgenerate

  always_comb begin
    eval = '0;
    for (int j = 0; j <= T; j++) eval = eval ^ r_q[j];
  end

  always_comb begin
    deg_d = '0;
    for (int j = 0; j <= T; j++)
      if (sigma_i[j*M +: M] != '0) deg_d = M'(j);
  end

  assign eval_zero = (eval == '0);
  assign count_inc = err_count_q + M'(eval_zero);
  // Position is the inverse exponent: k=0 -> 0, otherwise N-k.
  assign pos_now   = (k_q == '0) ? '0 : (N_V - k_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i)           state_d = S_RUN;
      S_RUN:  if (k_q == K_LAST)     state_d = S_WAIT;
      S_WAIT: if (accepted_i)        state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en    = (state_q == S_IDLE) && start_i;
    step_en    = (state_q == S_RUN);
    release_en = (state_q == S_WAIT) && accepted_i;
    last_step  = step_en && (k_q == K_LAST);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_q         <= '0;
      k_q         <= '0;
      deg_q       <= '0;
      err_count_q <= '0;
      err_pos_q   <= '0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      if (load_en) begin
        r_q         <= r_load;
        k_q         <= '0;
        err_count_q <= '0;
        fail_q      <= 1'b0;
        deg_q       <= deg_d;
        busy_q      <= 1'b1;
      end else if (step_en) begin
        r_q         <= r_step;
        k_q         <= k_q + 1'b1;
        err_count_q <= count_inc;
        if (last_step) fail_q <= (count_inc != deg_q);
      end else if (release_en) begin
        busy_q      <= 1'b0;
      end
      err_valid_q <= step_en;
      err_q       <= step_en && eval_zero;
      if (step_en) err_pos_q <= pos_now;
      done_q      <= last_step;
    end
  end

  assign busy_o      = busy_q;
  assign err_valid_o = err_valid_q;
  assign err_o       = err_q;
  assign err_pos_o   = err_pos_q;
  assign done_o      = done_q;
  assign err_count_o = err_count_q;
  assign fail_o      = fail_q;

endmodule
